// File: rtl/dtw_pkg.sv
// Shared types and constants for the DTW cell scheduler.
// State codes driven to the datapath, FSM states, default widths.
package dtw_pkg;

  localparam int DEF_DATA_W = 32;
  localparam int DEF_ADDR_W = 6;
  localparam int DEF_LEN_W  = 7;

  localparam logic [3:0] ST_IDLE      = 4'd0;
  localparam logic [3:0] ST_INIT      = 4'd1;
  localparam logic [3:0] ST_HOLD      = 4'd2;
  localparam logic [3:0] ST_FIRST     = 4'd3;
  localparam logic [3:0] ST_ROW0      = 4'd4;
  localparam logic [3:0] ST_ODD_COL0  = 4'd5;
  localparam logic [3:0] ST_ODD_INT   = 4'd6;
  localparam logic [3:0] ST_EVEN_COL0 = 4'd7;
  localparam logic [3:0] ST_EVEN_INT  = 4'd8;

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_DIST,
    S_READ,
    S_EXEC,
    S_WRITE,
    S_FIN
  } fsm_t;

endpackage

// File: rtl/dtw_addr_gen.sv
// Maps cell (i,j) to datapath state code and row-buffer read addresses.
// Ports: i_i/j_i cell index in; code_o, even/odd port A/B addresses out.
module dtw_addr_gen
  import dtw_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic [LEN_W-1:0]  i_i,
  input  logic [LEN_W-1:0]  j_i,
  output logic [3:0]        code_o,
  output logic [ADDR_W-1:0] even_a_o,
  output logic [ADDR_W-1:0] even_b_o,
  output logic [ADDR_W-1:0] odd_a_o,
  output logic [ADDR_W-1:0] odd_b_o
);

  logic [ADDR_W-1:0] j;
  logic [ADDR_W-1:0] jm1;
  logic row0, col0, odd;

  assign j    = j_i[ADDR_W-1:0];
  assign jm1  = j - ADDR_W'(1);
  assign row0 = (i_i == '0);
  assign col0 = (j_i == '0);
  assign odd  = i_i[0];

  always_comb begin
    code_o   = ST_FIRST;
    even_a_o = '0;
    even_b_o = '0;
    odd_a_o  = '0;
    odd_b_o  = '0;
    unique case (1'b1)
      row0 && col0: code_o = ST_FIRST;
      row0 && !col0: begin
        code_o   = ST_ROW0;
        even_b_o = jm1;
      end
      odd && col0: code_o = ST_ODD_COL0;
      odd && !col0: begin
        code_o   = ST_ODD_INT;
        even_a_o = j;
        even_b_o = jm1;
        odd_b_o  = jm1;
      end
      !row0 && !odd && col0: code_o = ST_EVEN_COL0;
      default: begin
        code_o   = ST_EVEN_INT;
        odd_a_o  = j;
        odd_b_o  = jm1;
        even_b_o = jm1;
      end
    endcase
  end

endmodule

// File: rtl/dtw_cell_scheduler.sv
// Sequences the DTW datapath over a q_len x t_len matrix, row-major.
// Ports: start/lengths in, busy/done/len_err/result out, distance
// handshake, datapath state code/enable, row-buffer addresses/writes.
module dtw_cell_scheduler
  import dtw_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [LEN_W-1:0]  q_len,
  input  logic [LEN_W-1:0]  t_len,
  output logic              busy,
  output logic              done,
  output logic              len_err,
  output logic [DATA_W-1:0] result,
  output logic              dist_req,
  output logic [LEN_W-1:0]  dist_i,
  output logic [LEN_W-1:0]  dist_j,
  input  logic              dist_valid,
  output logic [3:0]        states,
  output logic              comp_en,
  output logic [ADDR_W-1:0] even_addra,
  output logic [ADDR_W-1:0] even_addrb,
  output logic [ADDR_W-1:0] odd_addra,
  output logic [ADDR_W-1:0] odd_addrb,
  output logic [ADDR_W-1:0] wr_addr,
  output logic              even_we,
  output logic              odd_we,
  input  logic [DATA_W-1:0] cell_in
);

  localparam logic [LEN_W-1:0] T_MAX = LEN_W'(2**ADDR_W);

  fsm_t              state_q, state_d;
  logic [LEN_W-1:0]  i_q, i_d, j_q, j_d;
  logic [LEN_W-1:0]  ql_q, ql_d, tl_q, tl_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] res_q, res_d;
  logic              bad, last_col, last;

  logic [3:0]        code;
  logic [ADDR_W-1:0] g_ea, g_eb, g_oa, g_ob;

  dtw_addr_gen #(
    .ADDR_W(ADDR_W),
    .LEN_W (LEN_W)
  ) u_gen (
    .i_i     (i_q),
    .j_i     (j_q),
    .code_o  (code),
    .even_a_o(g_ea),
    .even_b_o(g_eb),
    .odd_a_o (g_oa),
    .odd_b_o (g_ob)
  );

  assign bad = (q_len == '0) || (t_len == '0) || (t_len > T_MAX);
  assign last_col = (j_q == tl_q - LEN_W'(1));
  assign last = last_col && (i_q == ql_q - LEN_W'(1));

  assign dist_i = i_q;
  assign dist_j = j_q;
  assign result = res_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      i_q     <= '0;
      j_q     <= '0;
      ql_q    <= '0;
      tl_q    <= '0;
      err_q   <= 1'b0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      i_q     <= i_d;
      j_q     <= j_d;
      ql_q    <= ql_d;
      tl_q    <= tl_d;
      err_q   <= err_d;
      res_q   <= res_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    i_d        = i_q;
    j_d        = j_q;
    ql_d       = ql_q;
    tl_d       = tl_q;
    err_d      = err_q;
    res_d      = res_q;
    busy       = 1'b0;
    done       = 1'b0;
    len_err    = 1'b0;
    dist_req   = 1'b0;
    comp_en    = 1'b0;
    states     = ST_IDLE;
    even_addra = '0;
    even_addrb = '0;
    odd_addra  = '0;
    odd_addrb  = '0;
    wr_addr    = '0;
    even_we    = 1'b0;
    odd_we     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          ql_d    = q_len;
          tl_d    = t_len;
          res_d   = '0;
          err_d   = bad;
          i_d     = '0;
          j_d     = '0;
          state_d = bad ? S_FIN : S_INIT;
        end
      end
      S_INIT: begin
        busy    = 1'b1;
        states  = ST_INIT;
        i_d     = '0;
        j_d     = '0;
        state_d = S_DIST;
      end
      S_DIST: begin
        busy     = 1'b1;
        states   = ST_HOLD;
        dist_req = 1'b1;
        if (dist_valid) state_d = S_READ;
      end
      S_READ, S_EXEC: begin
        busy       = 1'b1;
        states     = (state_q == S_EXEC) ? code : ST_HOLD;
        comp_en    = (state_q == S_EXEC);
        even_addra = g_ea;
        even_addrb = g_eb;
        odd_addra  = g_oa;
        odd_addrb  = g_ob;
        state_d    = (state_q == S_EXEC) ? S_WRITE : S_EXEC;
      end
      S_WRITE: begin
        busy    = 1'b1;
        comp_en = 1'b1;
        states  = ST_HOLD;
        wr_addr = j_q[ADDR_W-1:0];
        even_we = ~i_q[0];
        odd_we  = i_q[0];
        if (last) begin
          res_d   = cell_in;
          state_d = S_FIN;
        end else begin
          state_d = S_DIST;
          if (last_col) begin
            j_d = '0;
            i_d = i_q + LEN_W'(1);
          end else begin
            j_d = j_q + LEN_W'(1);
          end
        end
      end
      S_FIN: begin
        busy    = 1'b1;
        done    = 1'b1;
        len_err = err_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_dtw_cell_scheduler.sv
// Bench for dtw_cell_scheduler with 1-cycle row BRAMs and a DTW datapath.
// Table of runs plus hand sequences for trace, error timing and reset.
module tb_dtw_cell_scheduler;
  import dtw_pkg::*;

  localparam int DW = 32;
  localparam int AW = 6;
  localparam int LW = 7;

  logic          clk = 1'b0;
  logic          rst, start;
  logic [LW-1:0] q_len, t_len;
  logic          busy, done, len_err;
  logic [DW-1:0] result;
  logic          dist_req;
  logic [LW-1:0] dist_i, dist_j;
  logic          dist_valid;
  logic [3:0]    states;
  logic          comp_en;
  logic [AW-1:0] even_addra, even_addrb, odd_addra, odd_addrb, wr_addr;
  logic          even_we, odd_we;
  logic [DW-1:0] cell_in;

  always #5 clk = ~clk;

  dtw_cell_scheduler dut (
    .clk(clk), .rst(rst), .start(start),
    .q_len(q_len), .t_len(t_len),
    .busy(busy), .done(done), .len_err(len_err), .result(result),
    .dist_req(dist_req), .dist_i(dist_i), .dist_j(dist_j),
    .dist_valid(dist_valid), .states(states), .comp_en(comp_en),
    .even_addra(even_addra), .even_addrb(even_addrb),
    .odd_addra(odd_addra), .odd_addrb(odd_addrb),
    .wr_addr(wr_addr), .even_we(even_we), .odd_we(odd_we),
    .cell_in(cell_in)
  );

  logic [DW-1:0] even_mem [64];
  logic [DW-1:0] odd_mem [64];
  logic [DW-1:0] ea_q, eb_q, oa_q, ob_q, cell_q, dist_val;

  function automatic logic [DW-1:0] min3(logic [DW-1:0] a, b, c);
    logic [DW-1:0] m;
    m = (a < b) ? a : b;
    return (m < c) ? m : c;
  endfunction

  always @(posedge clk) begin
    ea_q <= even_mem[even_addra];
    eb_q <= even_mem[even_addrb];
    oa_q <= odd_mem[odd_addra];
    ob_q <= odd_mem[odd_addrb];
    if (even_we) even_mem[wr_addr] <= cell_in;
    if (odd_we) odd_mem[wr_addr] <= cell_in;
  end

  always @(posedge clk) begin
    if (rst) cell_q <= '0;
    else if (comp_en) begin
      case (states)
        4'd3: cell_q <= dist_val;
        4'd4: cell_q <= dist_val + eb_q;
        4'd5: cell_q <= dist_val + ea_q;
        4'd6: cell_q <= dist_val + min3(ea_q, eb_q, ob_q);
        4'd7: cell_q <= dist_val + oa_q;
        4'd8: cell_q <= dist_val + min3(oa_q, ob_q, eb_q);
        default: cell_q <= '0;
      endcase
    end
  end
  assign cell_in = cell_q;

  logic [5:0][7:0] cur_d;
  int              cur_delay;
  int              cur_t;
  int              wcnt;

  function automatic logic [DW-1:0] dist_of(int i, int j);
    int idx;
    idx = i * cur_t + j;
    return (idx < 6) ? DW'(cur_d[idx]) : DW'(1);
  endfunction

  always @(negedge clk) begin
    if (dist_req) begin
      if (wcnt >= cur_delay) begin
        dist_valid = 1'b1;
        dist_val = dist_of(int'(dist_i), int'(dist_j));
      end else begin
        dist_valid = 1'b0;
        wcnt++;
      end
    end else begin
      dist_valid = 1'b0;
      wcnt = 0;
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, want %0d", nm, act, exp);
    end
  endtask

  typedef struct packed {
    int              q;
    int              t;
    int              dly;
    logic [5:0][7:0] d;
    int              res;
    logic            err;
    logic [5:0][3:0] codes;
    int              n;
  } vec_t;

  function automatic vec_t mk(int q, int t, int dly, logic [47:0] d,
                              int res, logic err, logic [23:0] codes,
                              int n);
    vec_t v;
    v.q = q; v.t = t; v.dly = dly; v.d = d; v.res = res;
    v.err = err; v.codes = codes; v.n = n;
    return v;
  endfunction

  task automatic start_run(input int q, input int t);
    @(negedge clk);
    q_len = LW'(q);
    t_len = LW'(t);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    int k, nc, ti, tj, cells;
    bit prev_v, fin;
    cur_d = v.d;
    cur_delay = v.dly;
    cur_t = v.t;
    cells = v.err ? 0 : v.q * v.t;
    start_run(v.q, v.t);
    k = 0; nc = 0; prev_v = 0; fin = 0;
    for (int cyc = 0; cyc < 3000 && !fin; cyc++) begin
      #1;
      ti = (v.t > 0) ? k / v.t : 0;
      tj = (v.t > 0) ? k % v.t : 0;
      if (prev_v)
        chk($sformatf("v%0d_read_after_valid", idx),
            {dist_req, comp_en, states}, {2'b00, 4'd2});
      prev_v = dist_req && dist_valid;
      if (dist_req)
        chk($sformatf("v%0d_dist_ij", idx), {dist_i, dist_j},
            {ti[LW-1:0], tj[LW-1:0]});
      if (comp_en && states != 4'd2) begin
        if (nc < v.n)
          chk($sformatf("v%0d_code%0d", idx, nc), states, v.codes[nc]);
        nc++;
      end
      if (comp_en && states == 4'd2) begin
        chk($sformatf("v%0d_wr_addr", idx), wr_addr, tj);
        chk($sformatf("v%0d_we", idx), {even_we, odd_we},
            {~ti[0], ti[0]});
        k++;
      end
      if (done) begin
        fin = 1;
        chk($sformatf("v%0d_result", idx), result, v.res);
        chk($sformatf("v%0d_len_err", idx), len_err, v.err);
      end else begin
        @(negedge clk);
      end
    end
    if (!fin) chk($sformatf("v%0d_timeout", idx), 0, 1);
    chk($sformatf("v%0d_cells", idx), k, cells);
    chk($sformatf("v%0d_execs", idx), nc, cells);
    @(negedge clk);
    #1;
    chk($sformatf("v%0d_idle_after", idx), {busy, done, len_err}, 3'b000);
  endtask

  vec_t tbl[10];
  logic [3:0] trace[5];
  logic [3:0] exp_tr[5];
  bit seen;

  initial begin
    for (int a = 0; a < 64; a++) begin
      even_mem[a] = '0;
      odd_mem[a] = '0;
    end
    rst = 1'b1; start = 1'b0; q_len = '0; t_len = '0;
    dist_valid = 1'b0; dist_val = '0; wcnt = 0;
    cur_d = '0; cur_delay = 0; cur_t = 1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ctrl", {busy, done, len_err, dist_req, comp_en,
                     even_we, odd_we}, 7'b0);
    chk("rst_states", states, 0);
    chk("rst_addrs", {even_addra, even_addrb, odd_addra, odd_addrb,
                      wr_addr}, 30'b0);
    chk("rst_result", result, 0);
    chk("rst_ij", {dist_i, dist_j}, 14'b0);
    @(negedge clk);
    rst = 1'b0;

    // 1x1 trace: INIT, DIST, READ, EXEC, WRITE, then FIN
    cur_d = 48'd5; cur_delay = 0; cur_t = 1;
    start_run(1, 1);
    for (int c = 0; c < 5; c++) begin
      #1;
      trace[c] = states;
      if (c == 4) begin
        chk("t1_even_we", {even_we, odd_we, wr_addr}, {2'b10, 6'd0});
      end
      @(negedge clk);
    end
    exp_tr[0] = 4'd1; exp_tr[1] = 4'd2; exp_tr[2] = 4'd2;
    exp_tr[3] = 4'd3; exp_tr[4] = 4'd2;
    for (int c = 0; c < 5; c++)
      chk($sformatf("t1_trace%0d", c), trace[c], exp_tr[c]);
    #1;
    chk("t1_done", {done, len_err}, 2'b10);
    chk("t1_result", result, 5);

    // length error: done/len_err pulse right after the start cycle
    @(negedge clk);
    q_len = LW'(0); t_len = LW'(3); start = 1'b1;
    #1;
    chk("err_start_cycle", {busy, done}, 2'b00);
    @(negedge clk);
    start = 1'b0;
    #1;
    chk("err_done", {done, len_err}, 2'b11);
    chk("err_result", result, 0);
    @(negedge clk);
    #1;
    chk("err_after", {busy, done, len_err}, 3'b000);

    // reset during EXEC of cell (1,0)
    cur_d = {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1};
    cur_delay = 0; cur_t = 2;
    start_run(2, 2);
    seen = 0;
    for (int c = 0; c < 100 && !seen; c++) begin
      #1;
      if (states == 4'd5) seen = 1;
      else @(negedge clk);
    end
    chk("rst_mid_reach", seen, 1);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("rst_mid_ctrl", {busy, done, len_err, dist_req, comp_en,
                         even_we, odd_we}, 7'b0);
    chk("rst_mid_states", states, 0);
    chk("rst_mid_addrs", {even_addra, even_addrb, odd_addra, odd_addrb,
                          wr_addr}, 30'b0);
    chk("rst_mid_result", result, 0);
    rst = 1'b0;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      #1;
      if (done || busy) seen = 1;
    end
    chk("rst_mid_quiet", seen, 0);

    tbl[0] = mk(2, 2, 0, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 2, 0,
                {4'd0, 4'd0, 4'd6, 4'd5, 4'd4, 4'd3}, 4);
    tbl[1] = mk(1, 1, 0, 48'd5, 5, 0, 24'd3, 1);
    tbl[2] = mk(3, 2, 0, {8'd2, 8'd2, 8'd1, 8'd3, 8'd2, 8'd1}, 4, 0,
                {4'd8, 4'd7, 4'd6, 4'd5, 4'd4, 4'd3}, 6);
    tbl[3] = mk(3, 1, 0, {8'd0, 8'd0, 8'd0, 8'd3, 8'd2, 8'd1}, 6, 0,
                {4'd0, 4'd0, 4'd0, 4'd7, 4'd5, 4'd3}, 3);
    tbl[4] = mk(2, 2, 5, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 2, 0,
                {4'd0, 4'd0, 4'd6, 4'd5, 4'd4, 4'd3}, 4);
    tbl[5] = mk(0, 3, 0, 48'd0, 0, 1, 24'd0, 0);
    tbl[6] = mk(2, 0, 0, 48'd0, 0, 1, 24'd0, 0);
    tbl[7] = mk(1, 65, 0, 48'd0, 0, 1, 24'd0, 0);
    tbl[8] = mk(1, 64, 0, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 64, 0,
                {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd3}, 6);
    tbl[9] = mk(2, 64, 1, {8'd1, 8'd1, 8'd1, 8'd1, 8'd1, 8'd1}, 64, 0,
                {4'd4, 4'd4, 4'd4, 4'd4, 4'd4, 4'd3}, 6);
    for (int v = 0; v < 10; v++) run_vec(tbl[v], v);

    // start while busy is ignored
    cur_d = 48'd7; cur_delay = 3; cur_t = 1;
    start_run(1, 1);
    q_len = LW'(3); t_len = LW'(3); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    seen = 0;
    for (int c = 0; c < 50 && !seen; c++) begin
      #1;
      if (done) seen = 1;
      else @(negedge clk);
    end
    chk("busy_start_done", seen, 1);
    chk("busy_start_result", result, 7);
    @(negedge clk);
    #1;
    chk("busy_start_idle", busy, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
